// File: rtl/pmu_pkg.sv
// Shared definitions for the PMU result drain: default frame geometry,
// drain FSM states and the stream FIFO entry layout.
package pmu_pkg;

  localparam int NUM_LANES = 240;
  localparam int OUT_W     = 17;
  localparam int IDX_W     = 8;

  typedef enum logic [1:0] {
    IDLE,
    TRIG,
    DRAIN,
    FLUSH
  } state_t;

  typedef struct packed {
    logic [OUT_W-1:0] data;
    logic [IDX_W-1:0] lane;
    logic             last;
  } fifo_entry_t;

endpackage

// File: rtl/pmu_stream_fifo2.sv
// Two-entry valid/ready FIFO. The head entry is held in a register, so the
// output data comes straight from a flop and stays put while stalled.
module pmu_stream_fifo2 #(
  parameter int WIDTH = 26
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] tail;
  logic [1:0]       count;
  logic             push;
  logic             pop;

  assign out_valid = (count != 2'd0);
  assign out_data  = head;
  assign pop       = out_valid & out_ready;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign in_ready  = (count != 2'd2) | out_ready;
  assign push      = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 2'd0;
      head  <= '0;
      tail  <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) head <= in_data;
          else               tail <= in_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          head  <= tail;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            head <= in_data;
          end else begin
            head <= tail;
            tail <= in_data;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: rtl/pmu_result_drain.sv
// Drains one frame of PMU wrapper results lane by lane into a 2-entry
// valid/ready stream, counting carry-out lanes and flagging protocol errors.
module pmu_result_drain #(
  parameter int NUM_LANES = pmu_pkg::NUM_LANES,
  parameter int OUT_W     = pmu_pkg::OUT_W,
  parameter int IDX_W     = pmu_pkg::IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             compute_start,
  output logic             read_en,
  input  logic [OUT_W-1:0] w_dout,
  input  logic             w_valid,
  input  logic             w_done,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [OUT_W-1:0] m_data,
  output logic [IDX_W-1:0] m_lane,
  output logic             m_last,
  output logic [IDX_W-1:0] ovf_count,
  output logic             frame_done,
  output logic             proto_err
);

  import pmu_pkg::*;

  typedef struct packed {
    logic [OUT_W-1:0] data;
    logic [IDX_W-1:0] lane;
    logic             last;
  } entry_t;

  state_t           state;
  state_t           state_next;
  logic [IDX_W-1:0] lane_cnt;
  logic             last_lane;
  logic             accept;
  logic             push;
  logic             fifo_in_ready;
  entry_t           in_entry;
  entry_t           out_entry;

  assign last_lane = (lane_cnt == IDX_W'(NUM_LANES - 1));
  assign accept    = (state == IDLE) & start;
  assign in_entry  = '{data: w_dout, lane: lane_cnt, last: last_lane};
  assign m_data    = out_entry.data;
  assign m_lane    = out_entry.lane;
  assign m_last    = out_entry.last;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next    = state;
    busy          = (state != IDLE);
    compute_start = 1'b0;
    push          = 1'b0;
    read_en       = 1'b0;
    frame_done    = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = TRIG;
      end
      TRIG: begin
        compute_start = 1'b1;
        state_next    = DRAIN;
      end
      DRAIN: begin
        push = fifo_in_ready;
        // The wrapper pointer already sits on the final lane; never step past it.
        read_en = push & ~last_lane;
        if (push && last_lane) state_next = FLUSH;
      end
      FLUSH: begin
        if (!m_valid) begin
          frame_done = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lane_cnt  <= '0;
      ovf_count <= '0;
      proto_err <= 1'b0;
    end else if (accept) begin
      lane_cnt  <= '0;
      ovf_count <= '0;
      proto_err <= 1'b0;
    end else if (push) begin
      if (!last_lane)          lane_cnt  <= lane_cnt + 1'b1;
      if (w_dout[OUT_W-1])     ovf_count <= ovf_count + 1'b1;
      if (!w_valid || (w_done != last_lane)) proto_err <= 1'b1;
    end
  end

  pmu_stream_fifo2 #(
    .WIDTH($bits(entry_t))
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (state == DRAIN),
    .in_ready  (fifo_in_ready),
    .in_data   (in_entry),
    .out_valid (m_valid),
    .out_ready (m_ready),
    .out_data  (out_entry)
  );

endmodule

// File: tb/tb_pmu_result_drain.sv
// Directed bench for pmu_result_drain with a behavioural wrapper read port.
module tb_pmu_result_drain;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy;
  logic        compute_start;
  logic        read_en;
  logic [16:0] w_dout;
  logic        w_valid;
  logic        w_done;
  logic        m_valid;
  logic        m_ready;
  logic [16:0] m_data;
  logic [7:0]  m_lane;
  logic        m_last;
  logic [7:0]  ovf_count;
  logic        frame_done;
  logic        proto_err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pmu_result_drain dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .busy          (busy),
    .compute_start (compute_start),
    .read_en       (read_en),
    .w_dout        (w_dout),
    .w_valid       (w_valid),
    .w_done        (w_done),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_data        (m_data),
    .m_lane        (m_lane),
    .m_last        (m_last),
    .ovf_count     (ovf_count),
    .frame_done    (frame_done),
    .proto_err     (proto_err)
  );

  // Behavioural wrapper: captures on compute_start, steps on read_en.
  logic [16:0] lane_val [240];
  logic [16:0] exp_data [240];
  logic [7:0]  rd_ptr;
  logic        wrap_valid;
  int          bad_valid_lane = -1;
  int          early_done_lane = -1;

  always @(posedge clk) begin
    if (rst) begin
      rd_ptr     <= 8'd0;
      wrap_valid <= 1'b0;
    end else if (compute_start) begin
      rd_ptr     <= 8'd0;
      wrap_valid <= 1'b1;
    end else if (read_en && rd_ptr < 8'd239) begin
      rd_ptr <= rd_ptr + 8'd1;
    end
  end

  assign w_dout  = lane_val[rd_ptr];
  assign w_valid = wrap_valid && (int'(rd_ptr) != bad_valid_lane);
  assign w_done  = (rd_ptr == 8'd239) || (int'(rd_ptr) == early_done_lane);

  int          cs_cnt, cs_cycle, first_valid, re_cnt, beats;
  int          last_cnt, last_cycle, last_bad, fd_cnt, fd_cycle, idle_cycle;
  int          stab_err, occ_err, ovf_c1, perr_c1, perr_cycle;
  int          recv_cnt [240];
  logic [16:0] recv_data [240];

  function automatic int count_bad_lanes();
    int bad = 0;
    for (int k = 0; k < 240; k++)
      if (recv_cnt[k] != 1 || recv_data[k] !== exp_data[k]) bad++;
    return bad;
  endfunction

  // Starts a frame and records what the stream does, cycle by cycle after E0.
  task automatic run_frame(input int ready_pct, input int stop_lane, input int restart_at);
    logic        stalled = 1'b0;
    logic [16:0] hold_data = '0;
    logic [7:0]  hold_lane = '0;
    logic        hold_last = 1'b0;
    cs_cnt = 0; cs_cycle = -1; first_valid = -1; re_cnt = 0; beats = 0;
    last_cnt = 0; last_cycle = -1; last_bad = 0; fd_cnt = 0; fd_cycle = -1;
    idle_cycle = -1; stab_err = 0; occ_err = 0; ovf_c1 = -1; perr_c1 = -1; perr_cycle = -1;
    for (int k = 0; k < 240; k++) begin
      recv_cnt[k]  = 0;
      recv_data[k] = '0;
    end
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 4000; c++) begin
      @(negedge clk);
      start   = (c == restart_at);
      m_ready = (ready_pct >= 100) ? 1'b1 : (int'($urandom_range(0, 99)) < ready_pct);
      #1;
      if (c == 1) begin
        ovf_c1  = int'(ovf_count);
        perr_c1 = int'(proto_err);
      end
      if (compute_start) begin
        cs_cnt++;
        if (cs_cycle < 0) cs_cycle = c;
      end
      if (read_en) re_cnt++;
      if (proto_err && perr_cycle < 0) perr_cycle = c;
      if (dut.u_fifo.count > 2'd2) occ_err++;
      if (stalled && (!m_valid || m_data !== hold_data || m_lane !== hold_lane || m_last !== hold_last))
        stab_err++;
      if (m_valid && first_valid < 0) first_valid = c;
      if (m_valid && m_ready) begin
        beats++;
        if (m_lane < 8'd240) begin
          recv_cnt[m_lane]++;
          recv_data[m_lane] = m_data;
        end
        if (m_last) begin
          last_cnt++;
          last_cycle = c;
          if (m_lane != 8'd239) last_bad++;
        end
      end
      stalled   = m_valid && !m_ready;
      hold_data = m_data;
      hold_lane = m_lane;
      hold_last = m_last;
      if (frame_done) begin
        fd_cnt++;
        fd_cycle = c;
      end
      if (!busy) begin
        idle_cycle = c;
        break;
      end
      if (m_valid && m_ready && int'(m_lane) == stop_lane) break;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; m_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (m_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_m_valid: got %b expected 0", m_valid); end
    checks++; if (compute_start !== 1'b0 || read_en !== 1'b0 || frame_done !== 1'b0) begin
      failures++; $display("[TB] FAIL reset_pulses: got cs=%b re=%b fd=%b expected 0 0 0", compute_start, read_en, frame_done);
    end
    checks++; if (m_data !== 17'h0 || m_lane !== 8'h0 || m_last !== 1'b0) begin
      failures++; $display("[TB] FAIL reset_stream: got %h/%0d/%b expected 0/0/0", m_data, m_lane, m_last);
    end
    checks++; if (ovf_count !== 8'd0 || proto_err !== 1'b0) begin
      failures++; $display("[TB] FAIL reset_status: got ovf=%0d perr=%b expected 0 0", ovf_count, proto_err);
    end
  endtask

  task automatic test_basic_frame();
    int bad;
    for (int k = 0; k < 240; k++) begin
      lane_val[k] = 17'(k) + 17'd1;
      exp_data[k] = 17'(k + 1);
    end
    run_frame(100, -1, -1);
    bad = count_bad_lanes();
    checks++; if (cs_cycle != 1 || cs_cnt != 1) begin failures++; $display("[TB] FAIL basic_compute_start: got cycle %0d count %0d expected 1 1", cs_cycle, cs_cnt); end
    checks++; if (first_valid != 3) begin failures++; $display("[TB] FAIL basic_first_valid: got %0d expected 3", first_valid); end
    checks++; if (beats != 240) begin failures++; $display("[TB] FAIL basic_beats: got %0d expected 240", beats); end
    checks++; if (bad != 0) begin failures++; $display("[TB] FAIL basic_lane_data: got %0d bad lanes expected 0", bad); end
    checks++; if (last_cnt != 1 || last_bad != 0 || last_cycle != 242) begin
      failures++; $display("[TB] FAIL basic_m_last: got count %0d cycle %0d expected 1 at 242", last_cnt, last_cycle);
    end
    checks++; if (fd_cnt != 1 || fd_cycle != 243) begin failures++; $display("[TB] FAIL basic_frame_done: got count %0d cycle %0d expected 1 at 243", fd_cnt, fd_cycle); end
    checks++; if (idle_cycle != 244) begin failures++; $display("[TB] FAIL basic_idle_cycle: got %0d expected 244", idle_cycle); end
    checks++; if (re_cnt != 239) begin failures++; $display("[TB] FAIL basic_read_en: got %0d expected 239", re_cnt); end
    checks++; if (ovf_count !== 8'd0 || proto_err !== 1'b0) begin
      failures++; $display("[TB] FAIL basic_status: got ovf=%0d perr=%b expected 0 0", ovf_count, proto_err);
    end
  endtask

  task automatic test_carry();
    int bad;
    for (int k = 0; k < 240; k++) begin
      lane_val[k] = (k < 10) ? (17'h0FFFF + 17'h00001) : 17'h0;
      exp_data[k] = (k < 10) ? 17'h10000 : 17'h0;
    end
    run_frame(100, -1, -1);
    bad = count_bad_lanes();
    checks++; if (bad != 0) begin failures++; $display("[TB] FAIL carry_lane_data: got %0d bad lanes expected 0", bad); end
    checks++; if (ovf_count !== 8'd10) begin failures++; $display("[TB] FAIL carry_ovf_count: got %0d expected 10", ovf_count); end
    repeat (5) @(negedge clk);
    checks++; if (ovf_count !== 8'd10) begin failures++; $display("[TB] FAIL carry_ovf_hold: got %0d expected 10", ovf_count); end
  endtask

  task automatic test_random_ready();
    int bad;
    for (int k = 0; k < 240; k++) begin
      lane_val[k] = 17'(k) + 17'd1;
      exp_data[k] = 17'(k + 1);
    end
    run_frame(30, -1, -1);
    bad = count_bad_lanes();
    checks++; if (ovf_c1 != 0) begin failures++; $display("[TB] FAIL random_ovf_cleared: got %0d expected 0", ovf_c1); end
    checks++; if (idle_cycle < 0) begin failures++; $display("[TB] FAIL random_timeout: got no return to idle expected idle"); end
    checks++; if (beats != 240 || bad != 0) begin failures++; $display("[TB] FAIL random_lanes: got %0d beats %0d bad expected 240 0", beats, bad); end
    checks++; if (stab_err != 0) begin failures++; $display("[TB] FAIL random_stall_stable: got %0d changes expected 0", stab_err); end
    checks++; if (occ_err != 0) begin failures++; $display("[TB] FAIL random_occupancy: got %0d over-full cycles expected 0", occ_err); end
    checks++; if (re_cnt != 239) begin failures++; $display("[TB] FAIL random_read_en: got %0d expected 239", re_cnt); end
    checks++; if (last_cnt != 1 || last_bad != 0 || fd_cnt != 1) begin
      failures++; $display("[TB] FAIL random_end: got last %0d fd %0d expected 1 1", last_cnt, fd_cnt);
    end
  endtask

  task automatic test_backpressure();
    int re = 0;
    int done = 0;
    for (int k = 0; k < 240; k++) begin
      lane_val[k] = 17'(k) + 17'd1;
      exp_data[k] = 17'(k + 1);
    end
    @(negedge clk);
    start = 1'b1; m_ready = 1'b0;
    @(posedge clk);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      if (read_en) re++;
    end
    checks++; if (re != 2) begin failures++; $display("[TB] FAIL bp_read_en_stalled: got %0d expected 2", re); end
    checks++; if (m_valid !== 1'b1 || m_lane !== 8'd0 || m_data !== exp_data[0]) begin
      failures++; $display("[TB] FAIL bp_head_hold: got v=%b lane=%0d data=%h expected 1 0 %h", m_valid, m_lane, m_data, exp_data[0]);
    end
    for (int c = 21; c <= 700; c++) begin
      @(negedge clk);
      m_ready = 1'b1;
      #1;
      if (read_en) re++;
      if (!busy) begin
        done = 1;
        break;
      end
    end
    checks++; if (done != 1 || re != 239) begin failures++; $display("[TB] FAIL bp_drain: got done=%0d read_en=%0d expected 1 239", done, re); end
  endtask

  task automatic test_restart_rst();
    int bad;
    for (int k = 0; k < 240; k++) begin
      lane_val[k] = (k < 10) ? (17'h0FFFF + 17'h00001) : 17'h0;
      exp_data[k] = (k < 10) ? 17'h10000 : 17'h0;
    end
    run_frame(100, 100, 10);
    checks++; if (cs_cnt != 1) begin failures++; $display("[TB] FAIL restart_ignored: got %0d triggers expected 1", cs_cnt); end
    checks++; if (busy !== 1'b1 || ovf_count !== 8'd10) begin
      failures++; $display("[TB] FAIL restart_midframe: got busy=%b ovf=%0d expected 1 10", busy, ovf_count);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || m_valid !== 1'b0 || read_en !== 1'b0 || compute_start !== 1'b0 || frame_done !== 1'b0) begin
      failures++; $display("[TB] FAIL rst_ctrl: got busy=%b v=%b re=%b cs=%b fd=%b expected all 0", busy, m_valid, read_en, compute_start, frame_done);
    end
    checks++; if (m_data !== 17'h0 || m_lane !== 8'd0 || m_last !== 1'b0 || ovf_count !== 8'd0 || proto_err !== 1'b0) begin
      failures++; $display("[TB] FAIL rst_data: got %h/%0d/%b ovf=%0d perr=%b expected all 0", m_data, m_lane, m_last, ovf_count, proto_err);
    end
    run_frame(100, -1, -1);
    bad = count_bad_lanes();
    checks++; if (beats != 240 || bad != 0 || fd_cycle != 243 || idle_cycle != 244) begin
      failures++; $display("[TB] FAIL rst_next_frame: got beats=%0d bad=%0d fd=%0d idle=%0d expected 240 0 243 244", beats, bad, fd_cycle, idle_cycle);
    end
    checks++; if (ovf_count !== 8'd10) begin failures++; $display("[TB] FAIL rst_next_ovf: got %0d expected 10", ovf_count); end
  endtask

  task automatic test_proto();
    for (int k = 0; k < 240; k++) begin
      lane_val[k] = 17'(k) + 17'd1;
      exp_data[k] = 17'(k + 1);
    end
    bad_valid_lane = 50;
    run_frame(100, -1, -1);
    bad_valid_lane = -1;
    checks++; if (perr_cycle != 53) begin failures++; $display("[TB] FAIL proto_valid_rise: got cycle %0d expected 53", perr_cycle); end
    checks++; if (proto_err !== 1'b1 || beats != 240 || count_bad_lanes() != 0) begin
      failures++; $display("[TB] FAIL proto_valid_frame: got perr=%b beats=%0d expected 1 240", proto_err, beats);
    end
    early_done_lane = 5;
    run_frame(100, -1, -1);
    early_done_lane = -1;
    checks++; if (perr_c1 != 0) begin failures++; $display("[TB] FAIL proto_clear_on_start: got %0d expected 0", perr_c1); end
    checks++; if (perr_cycle != 8) begin failures++; $display("[TB] FAIL proto_done_rise: got cycle %0d expected 8", perr_cycle); end
    checks++; if (proto_err !== 1'b1 || beats != 240 || fd_cnt != 1) begin
      failures++; $display("[TB] FAIL proto_done_sticky: got perr=%b beats=%0d fd=%0d expected 1 240 1", proto_err, beats, fd_cnt);
    end
    run_frame(100, -1, -1);
    checks++; if (perr_c1 != 0 || perr_cycle != -1 || proto_err !== 1'b0) begin
      failures++; $display("[TB] FAIL proto_clean: got c1=%0d rise=%0d perr=%b expected 0 -1 0", perr_c1, perr_cycle, proto_err);
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_carry();
    test_random_ready();
    test_backpressure();
    test_restart_rst();
    test_proto();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pmu_result_drain.md
# pmu_result_drain

Downstream drain stage for the PMU result wrapper. On a start request it triggers the wrapper's parallel capture (`compute_start`), then walks its serial `read_en`/`dout` port lane by lane. Each 17-bit result is pushed into a 2-entry output FIFO that presents a valid/ready stream with lane index and end-of-frame marker. It also counts carry-out lanes and flags wrapper protocol violations.

## Interface
- `NUM_LANES`, default 240: lanes per frame; must match the wrapper.
- `OUT_W`, default 17: result width; bit `OUT_W-1` is the carry-out.
- `IDX_W`, default 8: lane index / counter width; requires `2**IDX_W > NUM_LANES`.

Ports (reset `rst`, synchronous, active-high; clock `clk`):
- `clk`  in  1  clock.
- `rst`  in  1  synchronous active-high reset.
- `start`  in  1  drain request; sampled only in IDLE.
- `busy`  out  1  high whenever state is not IDLE.
- `compute_start`  out  1  one-cycle pulse to the wrapper.
- `read_en`  out  1  advance the wrapper's read pointer.
- `w_dout`  in  `OUT_W`  wrapper result for the current lane.
- `w_valid`  in  1  wrapper results valid.
- `w_done`  in  1  wrapper is at the last lane.
- `m_valid`  out  1  stream data valid.
- `m_ready`  in  1  stream consumer ready.
- `m_data`  out  `OUT_W`  lane result.
- `m_lane`  out  `IDX_W`  lane index of `m_data`.
- `m_last`  out  1  high with lane `NUM_LANES-1`.
- `ovf_count`  out  `IDX_W`  number of lanes with `w_dout[OUT_W-1]=1` in the current or last frame.
- `frame_done`  out  1  one-cycle pulse at end of frame.
- `proto_err`  out  1  sticky protocol error flag.

## Operation
- States and transitions:
  - IDLE: `start=1` → TRIG. On the same edge, clear `lane_cnt` and `ovf_count`.
  - TRIG: `compute_start=1` for exactly this cycle; next state is DRAIN.
  - DRAIN: a push happens when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
    - On push: write `{w_dout, lane_cnt, lane_cnt==NUM_LANES-1}` into the FIFO and increment `ovf_count` if the carry bit is set.
    - `read_en` equals push, except it is never asserted on the last lane.
    - If the pushed lane is `NUM_LANES-1`, next state is FLUSH; otherwise `lane_cnt` increments.
  - FLUSH: when the FIFO is empty → IDLE with `frame_done=1` for one cycle.
- FIFO: 2 entries, registered outputs.
  - `m_valid` means not empty.
  - A pop is `m_valid & m_ready`.
  - A simultaneous push and pop while full is legal and keeps the count at 2.
  - `m_data`, `m_lane` and `m_last` hold steady while `m_valid & !m_ready`.
- Protocol checks: set `proto_err` on a push with `w_valid=0`, or on a push where `w_done != (lane_cnt==NUM_LANES-1)`. `proto_err` is cleared only by `rst` or by an accepted `start`. Draining continues regardless.
- `start` outside IDLE is ignored; no queuing.
- `ovf_count` holds its value after the frame until the next accepted `start`. Maximum value is `NUM_LANES`; no wrap.
- `rst` mid-frame: return to IDLE, empty the FIFO, and drop the in-flight frame. The wrapper's own `rst` is driven independently.
- Reset values: all outputs 0. State is IDLE.

## Timing
- `start` sampled high at edge E0 → `compute_start` high in cycle 1 → wrapper captures at E1 → DRAIN from cycle 2, with `w_dout` showing lane 0.
- First `m_valid` is in cycle 3, carrying lane 0.
- With `m_ready` held high: one lane per cycle, lane k in cycle 3+k, `m_last` in cycle 242, `frame_done` in cycle 243, `busy` low from cycle 244.
- `read_en` is combinational from state, FIFO occupancy and `m_ready`. Each assertion advances the wrapper exactly once per pushed lane, so 239 pulses per frame.
- Backpressure: with `m_ready` held low, exactly 2 pushes occur, then `read_en` stays 0 until a pop.

## Structure
- Shared package `pmu_pkg`: `NUM_LANES`, `OUT_W`, `IDX_W`, the state enum (IDLE/TRIG/DRAIN/FLUSH), and the FIFO entry struct `{data, lane, last}`.
- One sub-module: `pmu_stream_fifo2`, a 2-entry valid/ready FIFO parameterised on entry width. The FSM, counters and checks live in the top level.

## Test plan
- Load lanes with A=k, B=1 through the wrapper, then pulse `start` with `m_ready=1` → 240 beats, `m_data=k+1`, `m_lane=k`, `m_last` only on k=239, `frame_done` in cycle 243, `ovf_count=0`.
- Set A=0xFFFF, B=0x0001 on lanes 0–9 and 0 elsewhere → lanes 0–9 give `m_data=0x10000`, `ovf_count=10`.
- Drive `m_ready` with a random 30% duty → no lost or duplicated lanes, `m_data` stable while stalled, FIFO never exceeds 2 entries, exactly 239 `read_en` pulses.
- Pulse `start` again during DRAIN, then assert `rst` at lane 100 → second start ignored; after `rst` all outputs are 0 and state is IDLE; the next `start` produces a full, clean 240-lane frame.
- Force `w_valid=0`, or tie `w_done=1` early at lane 5 → `proto_err` rises and stays high; the frame still completes; the next accepted `start` clears it.
